piso_serializer: RTL

Parallel-in/serial-out stage that sits directly upstream of the Moore sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial line. That line drives a detector's `in` port and is held at 0 when the stage is idle. Back-to-back words stream with no gap, so a detector sees a contiguous bit stream across word boundaries.

---
 rtl/piso_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// streams them one bit per clock, back-to-back with no gap between words.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_ord;
    logic             xfer;

    logic ser_out_q, ser_valid_q, done_q, ready_q;

    // LSB-first words are reversed on capture so the shifter always drains bit WIDTH-1.
    always_comb begin
        data_ord = data_in;
        if (!MSB_FIRST) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                data_ord[i] = data_in[int'(WIDTH) - 1 - i];
            end
        end
    end

    assign xfer = load_valid && ready_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d = StShift;
                    sreg_d  = data_ord;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    if (xfer) begin
                        sreg_d = data_ord;
                        cnt_d  = CW'(WIDTH - 1);
                    end else begin
                        state_d = StIdle;
                        sreg_d  = '0;
                    end
                end else begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are flops fed from next-state so they clear asynchronously with the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= (state_d == StShift) && sreg_d[WIDTH-1];
            ser_valid_q <= (state_d == StShift);
            done_q      <= (state_d == StShift) && (cnt_d == '0);
            ready_q     <= (state_d == StIdle) || (cnt_d == '0);
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign busy       = ser_valid_q;
    assign done       = done_q;
    // Held low while reset is asserted so nothing upstream believes a transfer happened.
    assign load_ready = ready_q && rst;

endmodule
